// File: rtl/redpitaya_dac_arbiter.sv
// Round-robin arbiter sharing one DAC sample stream between NREQ generators,
// with optional hold timeout, zero-sample guard between owners and PLL-lock gating.
module redpitaya_dac_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATA_SZ  = 14,
  parameter int GUARD    = 16,
  parameter int MAX_HOLD = 0
) (
  input  logic                      dac_clk_i,
  input  logic                      dac_rst_i,
  input  logic                      dac_locked_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ-1:0]           data_en_i,
  input  logic [NREQ*DATA_SZ-1:0]   data_i,
  output logic [NREQ-1:0]           gnt_o,
  output logic                      revoked_o,
  output logic                      busy_o,
  output logic                      dac_dat_en_o,
  output logic [DATA_SZ-1:0]        dac_dat_o
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (MAX_HOLD > GUARD) ? MAX_HOLD : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_GUARD
  } state_t;

  state_t              r_state;
  logic [NREQ-1:0]     r_gnt;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_revoked;
  logic                r_busy;
  logic                r_en;
  logic [DATA_SZ-1:0]  r_dat;

  logic [IDX_W-1:0]    w_pick;
  logic                w_found;
  logic [DATA_SZ-1:0]  w_own_dat;
  logic                w_own_req;
  logic                w_own_en;
  logic                w_others;
  logic                w_hold_exp;
  logic [IDX_W-1:0]    w_next_ptr;

  // First active request at or after the round-robin pointer, wrapping around.
  always_comb begin
    int idx;
    w_pick  = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_i[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_own_dat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gnt[k]) w_own_dat = data_i[k*DATA_SZ +: DATA_SZ];
    end
  end

  assign w_own_req  = |(req_i & r_gnt);
  assign w_own_en   = |(data_en_i & r_gnt);
  assign w_others   = |(req_i & ~r_gnt);
  assign w_hold_exp = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD));
  assign w_next_ptr = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + IDX_W'(1);

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_revoked <= 1'b0;
      r_busy    <= 1'b0;
      r_en      <= 1'b0;
      r_dat     <= '0;
    end else if (!dac_locked_i) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_revoked <= 1'b0;
      r_busy    <= 1'b0;
      r_en      <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_revoked <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_en  <= 1'b0;
          r_dat <= '0;
          r_cnt <= '0;
          if (w_found) begin
            r_state <= S_OWN;
            r_gnt   <= NREQ'(1) << w_pick;
            r_owner <= w_pick;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_OWN: begin
          if (w_own_en) begin
            r_dat <= w_own_dat;
            r_en  <= 1'b1;
          end else begin
            r_en <= 1'b0;
          end
          // A release wins over a coincident timeout, so revoked only flags a forced handover.
          if (!w_own_req || (w_hold_exp && w_others)) begin
            r_revoked <= w_own_req;
            r_gnt     <= '0;
            r_ptr     <= w_next_ptr;
            if (!w_own_en) begin
              r_dat <= '0;
              r_en  <= (GUARD != 0);
            end
            if (GUARD == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_state <= S_GUARD;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(1);
            end
          end else if ((MAX_HOLD != 0) && !w_hold_exp) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_GUARD: begin
          r_dat <= '0;
          if (r_cnt == CNT_W'(GUARD)) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_en  <= 1'b1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_en    <= 1'b0;
          r_dat   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign revoked_o    = r_revoked;
  assign busy_o       = r_busy;
  assign dac_dat_en_o = r_en;
  assign dac_dat_o    = r_dat;

endmodule

// File: tb/tb_redpitaya_dac_arbiter.sv
// Bench for redpitaya_dac_arbiter: directed scenarios with literal expectations plus a
// transaction-level reference model compared against the outputs on every cycle.
module tb_redpitaya_dac_arbiter;

  localparam int NREQ  = 4;
  localparam int DSZ   = 14;
  localparam int GUARD = 16;
  localparam int MAXH  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            locked;
  logic [3:0]      req;
  logic [3:0]      dataEn;
  logic [DSZ-1:0]  dataArr [NREQ];
  logic [NREQ*DSZ-1:0] dataBus;

  logic [3:0]      gnt;
  logic            revoked;
  logic            busy;
  logic            datEn;
  logic [DSZ-1:0]  dat;

  int checks   = 0;
  int failures = 0;

  int  mOwner;
  int  mGuardLeft;
  int  mHeld;
  int  mPtr;
  bit  modelValid = 0;
  logic [3:0]     eGnt;
  logic           eRev;
  logic           eBusy;
  logic           eEn;
  logic [DSZ-1:0] eDat;

  always #5 clk = ~clk;

  assign dataBus = {dataArr[3], dataArr[2], dataArr[1], dataArr[0]};

  redpitaya_dac_arbiter #(
    .NREQ(NREQ), .DATA_SZ(DSZ), .GUARD(GUARD), .MAX_HOLD(MAXH)
  ) dut (
    .dac_clk_i    (clk),
    .dac_rst_i    (rst),
    .dac_locked_i (locked),
    .req_i        (req),
    .data_en_i    (dataEn),
    .data_i       (dataBus),
    .gnt_o        (gnt),
    .revoked_o    (revoked),
    .busy_o       (busy),
    .dac_dat_en_o (datEn),
    .dac_dat_o    (dat)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the channel, how long they have held it, how many
  // zero samples remain before the channel is free, and where the search starts.
  task automatic modelStep();
    bit rel;
    bit others;
    bit timeout;
    int k;
    if (rst) begin
      modelValid = 1;
      mOwner = -1; mGuardLeft = 0; mHeld = 0; mPtr = 0;
      eGnt = 0; eRev = 0; eBusy = 0; eEn = 0; eDat = 0;
      return;
    end
    if (!locked) begin
      mOwner = -1; mGuardLeft = 0; mHeld = 0;
      eGnt = 0; eRev = 0; eBusy = 0; eEn = 0; eDat = 0;
      return;
    end
    eRev = 0;
    if (mOwner >= 0) begin
      k = mOwner;
      if (dataEn[k]) begin
        eDat = dataArr[k];
        eEn  = 1;
      end else begin
        eEn = 0;
      end
      rel     = !req[k];
      others  = (req & ~(4'b0001 << k)) != 4'b0;
      timeout = (mHeld >= MAXH) && others;
      if (rel || timeout) begin
        eRev       = !rel;
        mPtr       = (k + 1) % NREQ;
        mOwner     = -1;
        mGuardLeft = GUARD;
        eGnt       = 0;
        eBusy      = (GUARD > 0);
        if (!dataEn[k]) begin
          eDat = 0;
          eEn  = (GUARD > 0);
        end
      end else begin
        mHeld++;
        eBusy = 1;
      end
    end else if (mGuardLeft > 0) begin
      mGuardLeft--;
      eDat  = 0;
      eEn   = (mGuardLeft > 0);
      eBusy = (mGuardLeft > 0);
      eGnt  = 0;
    end else begin
      eDat  = 0;
      eEn   = 0;
      eBusy = 0;
      eGnt  = 0;
      for (int i = 0; i < NREQ; i++) begin
        k = (mPtr + i) % NREQ;
        if (mOwner < 0 && req[k]) begin
          mOwner = k;
          mHeld  = 1;
          eGnt   = 4'b0001 << k;
          eBusy  = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (modelValid) begin
      checkOutput("gnt",     32'(gnt),     32'(eGnt));
      checkOutput("revoked", 32'(revoked), 32'(eRev));
      checkOutput("busy",    32'(busy),    32'(eBusy));
      checkOutput("dat_en",  32'(datEn),   32'(eEn));
      checkOutput("dat",     32'(dat),     32'(eDat));
    end
  end

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [5];
    int lowCnt;
    int waitCnt;
    int k;
    logic [3:0] expG;
    seq = '{0, 1, 2, 3, 0};
    rst = 1; locked = 1; req = 0; dataEn = 0;
    for (int i = 0; i < NREQ; i++) dataArr[i] = '0;
    applyStimulus(3);
    checkOutput("rst_gnt",  32'(gnt),   32'h0);
    checkOutput("rst_busy", 32'(busy),  32'h0);
    checkOutput("rst_en",   32'(datEn), 32'h0);
    checkOutput("rst_dat",  32'(dat),   32'h0);
    rst = 0;
    applyStimulus(1);

    // Single requester, latency-1 data path, foreign data ignored.
    req = 4'b0100;
    applyStimulus(1);
    checkOutput("t1_gnt", 32'(gnt), 32'h4);
    dataEn = 4'b0110; dataArr[1] = 14'h0F0; dataArr[2] = 14'h1A5;
    applyStimulus(1);
    checkOutput("t1_dat", 32'(dat), 32'h1A5);
    checkOutput("t1_en",  32'(datEn), 32'h1);
    dataEn = 4'b0000;
    applyStimulus(1);
    checkOutput("t1_hold_dat", 32'(dat), 32'h1A5);
    checkOutput("t1_hold_en",  32'(datEn), 32'h0);
    req = 4'b0000;
    applyStimulus(1);
    checkOutput("t1_guard_gnt", 32'(gnt), 32'h0);
    checkOutput("t1_guard_en",  32'(datEn), 32'h1);
    checkOutput("t1_guard_dat", 32'(dat), 32'h0);
    applyStimulus(15);
    checkOutput("t1_guard_last", 32'(datEn), 32'h1);
    applyStimulus(1);
    checkOutput("t1_guard_end", 32'(datEn), 32'h0);
    checkOutput("t1_idle_busy", 32'(busy), 32'h0);

    // All four requesting, each owner drops after 10 cycles.
    rst = 1;
    applyStimulus(1);
    rst = 0; req = 4'b1111; dataEn = 4'b1010;
    dataArr[0] = 14'h011; dataArr[1] = 14'h122; dataArr[2] = 14'h233; dataArr[3] = 14'h344;
    lowCnt = 0;
    for (int g = 0; g < 5; g++) begin
      waitCnt = 0;
      do begin
        applyStimulus(1);
        waitCnt++;
        if (gnt == 4'b0) lowCnt++;
      end while (gnt == 4'b0 && waitCnt < 40);
      if (g > 0) checkOutput("t2_gap", 32'(lowCnt), 32'd17);
      expG = 4'b0001 << seq[g];
      checkOutput("t2_order", 32'(gnt), 32'(expG));
      k = seq[g];
      applyStimulus(9);
      req[k] = 1'b0;
      applyStimulus(1);
      req[k] = 1'b1;
      lowCnt = 1;
    end
    req = 4'b0000; dataEn = 4'b0000;
    applyStimulus(20);

    // Timeout: req0 held, req1 joins at cycle 5.
    req = 4'b0001;
    applyStimulus(1);
    checkOutput("t3_gnt0", 32'(gnt), 32'h1);
    applyStimulus(4);
    req = 4'b0011;
    applyStimulus(27);
    checkOutput("t3_still0", 32'(gnt), 32'h1);
    applyStimulus(1);
    checkOutput("t3_revoke_gnt", 32'(gnt), 32'h0);
    checkOutput("t3_revoke_pulse", 32'(revoked), 32'h1);
    applyStimulus(1);
    checkOutput("t3_pulse_end", 32'(revoked), 32'h0);
    applyStimulus(15);
    checkOutput("t3_gap_gnt", 32'(gnt), 32'h0);
    applyStimulus(1);
    checkOutput("t3_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    applyStimulus(20);

    // Lone requester is never revoked.
    req = 4'b0001;
    applyStimulus(1);
    checkOutput("t4_gnt", 32'(gnt), 32'h1);
    applyStimulus(100);
    checkOutput("t4_keep", 32'(gnt), 32'h1);

    // Lock loss mid-grant and recovery.
    dataEn = 4'b0001; dataArr[0] = 14'h3C7;
    applyStimulus(1);
    checkOutput("t5_dat", 32'(dat), 32'h3C7);
    locked = 0;
    applyStimulus(1);
    checkOutput("t5_unlock_gnt", 32'(gnt), 32'h0);
    checkOutput("t5_unlock_dat", 32'(dat), 32'h0);
    checkOutput("t5_unlock_en",  32'(datEn), 32'h0);
    applyStimulus(5);
    checkOutput("t5_nogrant", 32'(gnt), 32'h0);
    locked = 1;
    applyStimulus(1);
    checkOutput("t5_regrant", 32'(gnt), 32'h1);

    // Release with a final sample, then reset during guard.
    req = 4'b0000; dataArr[0] = 14'h2A3;
    applyStimulus(1);
    checkOutput("t6_last_dat", 32'(dat), 32'h2A3);
    checkOutput("t6_last_en",  32'(datEn), 32'h1);
    dataEn = 4'b0000;
    applyStimulus(1);
    checkOutput("t6_guard_dat", 32'(dat), 32'h0);
    checkOutput("t6_guard_en",  32'(datEn), 32'h1);
    applyStimulus(2);
    rst = 1;
    applyStimulus(1);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    checkOutput("t6_rst_en",   32'(datEn), 32'h0);
    checkOutput("t6_rst_gnt",  32'(gnt), 32'h0);
    rst = 0; req = 4'b1001;
    applyStimulus(1);
    checkOutput("t6_ptr_reset", 32'(gnt), 32'h1);
    applyStimulus(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
